// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter stage: FSM encodings and
// next-PC constants.
package pc_unit_pkg;

    localparam int PC_W_DEF = 32;
    localparam int PC_INCR  = 4;

    typedef enum logic [1:0] {
        S_BOOT  = 2'b00,
        S_RUN   = 2'b01,
        S_STALL = 2'b10
    } pc_state_t;

endpackage

// File: rtl/pc_target_adder.sv
// Combinational next-PC arithmetic: sequential successor and the
// offset-relative branch/jump target, both modulo 2^PC_W.
import pc_unit_pkg::*;

module pc_target_adder #(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0] pc,
    input  logic [7:0]      offset,
    output logic [PC_W-1:0] pc_plus4,
    output logic [PC_W-1:0] target
);

    logic [PC_W-1:0] offset_ext_s;

    // Word offset is relative to the following instruction, not the current one.
    always_comb begin
        offset_ext_s = {{(PC_W-8){offset[7]}}, offset};
        pc_plus4     = pc + PC_W'(PC_INCR);
        target       = pc_plus4 + (offset_ext_s << 2);
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: holds PC, selects the next PC from control_unit
// enables, stalls on memory busywait and counts retired instructions.
import pc_unit_pkg::*;

module pc_unit #(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              BEQ_ENABLE,
    input  logic              BNE_ENABLE,
    input  logic              JUMP_ENABLE,
    input  logic              ZERO,
    input  logic [7:0]        OFFSET,
    input  logic              IMEM_BUSYWAIT,
    input  logic              DMEM_BUSYWAIT,
    output logic [PC_W-1:0]   PC,
    output logic              PC_VALID,
    output logic              BRANCH_TAKEN,
    output logic [CNT_W-1:0]  RETIRED
);

    pc_state_t       state_r;
    pc_state_t       state_next_s;
    logic            stall_s;
    logic            update_s;
    logic            valid_next_s;
    logic            redirect_s;
    logic [PC_W-1:0] pc_plus4_s;
    logic [PC_W-1:0] target_s;
    logic [PC_W-1:0] pc_next_s;

    assign stall_s = IMEM_BUSYWAIT | DMEM_BUSYWAIT;

    pc_target_adder #(
        .PC_W (PC_W)
    ) u_adder (
        .pc       (PC),
        .offset   (OFFSET),
        .pc_plus4 (pc_plus4_s),
        .target   (target_s)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r <= S_BOOT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; leaving S_STALL never updates PC on that edge.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_BOOT:  state_next_s = S_RUN;
            S_RUN:   state_next_s = stall_s ? S_STALL : S_RUN;
            S_STALL: state_next_s = stall_s ? S_STALL : S_RUN;
            default: state_next_s = S_BOOT;
        endcase
    end

    // FSM outputs: whether this edge commits an instruction, and next PC_VALID.
    always_comb begin
        update_s     = 1'b0;
        valid_next_s = (state_next_s == S_RUN);
        case (state_r)
            S_RUN:   update_s = !stall_s;
            default: update_s = 1'b0;
        endcase
    end

    // Redirect selection; jump has priority over conditional branches.
    always_comb begin
        redirect_s = 1'b0;
        if (JUMP_ENABLE) begin
            redirect_s = 1'b1;
        end else if (BEQ_ENABLE && ZERO) begin
            redirect_s = 1'b1;
        end else if (BNE_ENABLE && !ZERO) begin
            redirect_s = 1'b1;
        end else begin
            redirect_s = 1'b0;
        end
        pc_next_s = redirect_s ? target_s : pc_plus4_s;
    end

    // PC, status flags and saturating retired counter.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            PC           <= RESET_PC;
            PC_VALID     <= 1'b0;
            BRANCH_TAKEN <= 1'b0;
            RETIRED      <= '0;
        end else begin
            PC_VALID <= valid_next_s;
            if (update_s) begin
                PC           <= pc_next_s;
                BRANCH_TAKEN <= redirect_s;
                if (RETIRED != {CNT_W{1'b1}}) begin
                    RETIRED <= RETIRED + CNT_W'(1);
                end
            end
        end
    end

endmodule
